// File: rtl/enc_sched_pkg.sv
// Shared types and defaults for the encoder chunk scheduler.
// Optional build macro used by the top: ENC_SCHED_PERF_EN (busy-cycle counter).
package enc_sched_pkg;

    localparam int DEF_NUM_CHUNKS = 8;
    localparam int DEF_BIND_LAT   = 1;
    // Binder-pack latency is at most 15 cycles, so a 4-bit counter holds BIND_LAT-1.
    localparam int LAT_W          = 4;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        BIND,
        WAIT,
        ACC,
        DONE
    } sched_state_e;

    // Every scheduler output except chunk_idx is a pure decode of the state.
    typedef struct packed {
        logic sample_ready;
        logic fetch_en;
        logic start_encoding;
        logic bind_valid;
        logic enc_done;
        logic busy;
    } sched_out_t;

    function automatic sched_out_t decode_outputs(input sched_state_e s);
        sched_out_t o;
        o.sample_ready   = (s == IDLE);
        o.fetch_en       = (s == FETCH);
        o.start_encoding = (s == BIND);
        o.bind_valid     = (s == ACC);
        o.enc_done       = (s == DONE);
        o.busy           = (s != IDLE);
        return o;
    endfunction

endpackage

// File: rtl/enc_lat_counter.sv
// Binder-pack latency counter: load a start value, count down to zero, flag zero.
// The count holds at zero rather than wrapping.
module enc_lat_counter
    import enc_sched_pkg::*;
#(
    parameter int W = LAT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] count;

    // load wins over decrement; decrement stops at zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (dec && (count != '0))
            count <= count - W'(1);
    end

    assign zero = (count == '0);

endmodule

// File: rtl/enc_chunk_sched.sv
// Encoder chunk scheduler: walks NUM_CHUNKS chunks per sample through
// fetch -> bind -> wait(BIND_LAT) -> accumulate, then pulses enc_done.
// Optional build macro: ENC_SCHED_PERF_EN adds the cycle_count output.
module enc_chunk_sched
    import enc_sched_pkg::*;
#(
    parameter int NUM_CHUNKS = DEF_NUM_CHUNKS,
    parameter int BIND_LAT   = DEF_BIND_LAT,
    parameter int CHUNK_W    = $clog2(NUM_CHUNKS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sample_valid,
    output logic               sample_ready,
    input  logic               abort,
    output logic [CHUNK_W-1:0] chunk_idx,
    output logic               fetch_en,
    output logic               start_encoding,
    output logic               bind_valid,
    input  logic               acc_ready,
    output logic               enc_done,
    output logic               busy
`ifdef ENC_SCHED_PERF_EN
    ,
    output logic [31:0]        cycle_count
`endif
);

    localparam logic [CHUNK_W-1:0] LAST_CHUNK = CHUNK_W'(NUM_CHUNKS - 1);
    // WAIT lasts BIND_LAT cycles: it exits in the cycle after the count reads zero.
    localparam logic [LAT_W-1:0]   LAT_LOAD   = LAT_W'(BIND_LAT - 1);

    sched_state_e state, state_nxt;
    sched_out_t   outs;
    logic         lat_zero;
    logic         accept;
    logic         handshake;

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // next state plus state-decoded strobes; abort overrides every transition
    always_comb begin
        state_nxt = state;
        outs      = decode_outputs(state);
        accept    = (state == IDLE) && sample_valid && !abort;
        handshake = (state == ACC) && acc_ready;
        case (state)
            IDLE:    if (sample_valid) state_nxt = FETCH;
            FETCH:   state_nxt = BIND;
            BIND:    state_nxt = WAIT;
            WAIT:    if (lat_zero) state_nxt = ACC;
            ACC:     if (acc_ready) state_nxt = (chunk_idx == LAST_CHUNK) ? DONE : FETCH;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (abort)
            state_nxt = IDLE;
    end

    // chunk index: cleared on accept/abort, advanced only on a non-final handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            chunk_idx <= '0;
        else if (abort || accept)
            chunk_idx <= '0;
        else if (handshake && (chunk_idx != LAST_CHUNK))
            chunk_idx <= chunk_idx + CHUNK_W'(1);
    end

    enc_lat_counter #(
        .W        (LAT_W)
    ) u_lat (
        .clk      (clk),
        .rst      (rst),
        .load     (state == BIND),
        .dec      (state == WAIT),
        .load_val (LAT_LOAD),
        .zero     (lat_zero)
    );

    assign sample_ready   = outs.sample_ready;
    assign fetch_en       = outs.fetch_en;
    assign start_encoding = outs.start_encoding;
    assign bind_valid     = outs.bind_valid;
    assign enc_done       = outs.enc_done;
    assign busy           = outs.busy;

`ifdef ENC_SCHED_PERF_EN
    // busy-cycle counter; the accept cycle counts as the first cycle of the sample
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cycle_count <= '0;
        else if (accept)
            cycle_count <= 32'd1;
        else if (outs.busy && (cycle_count != '1))
            cycle_count <= cycle_count + 32'd1;
    end
`endif

endmodule

// File: tb/tb_enc_chunk_sched.sv
// Scoreboard bench for enc_chunk_sched: two instances (8 chunks / latency 1 and
// 5 chunks / latency 4) driven with randomized samples, stalls, aborts and resets.
// Expected event times come from cycle arithmetic on the chunk schedule.
module tb_enc_chunk_sched;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp   = 0;
    int n_bad   = 0;
    int fin_cnt = 0;

    typedef struct {
        int kind;   // 0 fetch, 1 bind, 2 acc-entry, 3 handshake, 4 done
        int cy;
        int chunk;
    } ev_t;

    function automatic string kname(input int k);
        case (k)
            0:       return "fetch";
            1:       return "bind";
            2:       return "acc_entry";
            3:       return "handshake";
            default: return "done";
        endcase
    endfunction

    task automatic check(input string name, input int g, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s [dut%0d] cyc %0d: got %0d, want %0d", name, g, cyc, act, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : u
        localparam int NC  = (g == 0) ? 8 : 5;
        localparam int LAT = (g == 0) ? 1 : 4;
        localparam int CW  = $clog2(NC);

        logic          rst;
        logic          sample_valid;
        logic          sample_ready;
        logic          abort;
        logic [CW-1:0] chunk_idx;
        logic          fetch_en;
        logic          start_encoding;
        logic          bind_valid;
        logic          acc_ready;
        logic          enc_done;
        logic          busy;
`ifdef ENC_SCHED_PERF_EN
        logic [31:0]   cycle_count;
`endif
        ev_t  q[$];
        logic prev_bv = 1'b0;

        enc_chunk_sched #(
            .NUM_CHUNKS     (NC),
            .BIND_LAT       (LAT),
            .CHUNK_W        (CW)
        ) dut (
            .clk            (clk),
            .rst            (rst),
            .sample_valid   (sample_valid),
            .sample_ready   (sample_ready),
            .abort          (abort),
            .chunk_idx      (chunk_idx),
            .fetch_en       (fetch_en),
            .start_encoding (start_encoding),
            .bind_valid     (bind_valid),
            .acc_ready      (acc_ready),
            .enc_done       (enc_done),
            .busy           (busy)
`ifdef ENC_SCHED_PERF_EN
            ,
            .cycle_count    (cycle_count)
`endif
        );

        task automatic push(input int k, input int cy, input int ch);
            ev_t e;
            e.kind  = k;
            e.cy    = cy;
            e.chunk = ch;
            q.push_back(e);
        endtask

        task automatic chk_reset_outs(input string tag);
            check({tag, "_sample_ready"},   g, sample_ready,   1);
            check({tag, "_busy"},           g, busy,           0);
            check({tag, "_fetch_en"},       g, fetch_en,       0);
            check({tag, "_start_encoding"}, g, start_encoding, 0);
            check({tag, "_bind_valid"},     g, bind_valid,     0);
            check({tag, "_enc_done"},       g, enc_done,       0);
            check({tag, "_chunk_idx"},      g, int'(chunk_idx), 0);
        endtask

        task automatic observe(input int k);
            ev_t e;
            if (q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_%s [dut%0d] cyc %0d: got event, want none", kname(k), g, cyc);
                return;
            end
            e = q.pop_front();
            check({kname(k), "_kind"},  g, k,               e.kind);
            check({kname(k), "_cycle"}, g, cyc,             e.cy);
            check({kname(k), "_chunk"}, g, int'(chunk_idx), e.chunk);
        endtask

        // monitor: sample just after the falling edge, when this cycle's inputs are settled
        initial begin
            forever begin
                @(negedge clk);
                #1;
                while (q.size() > 0 && q[0].cy < cyc) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL missed_%s [dut%0d] cyc %0d: got nothing, want event at cyc %0d",
                             kname(q[0].kind), g, cyc, q[0].cy);
                    void'(q.pop_front());
                end
                if (fetch_en)                observe(0);
                if (start_encoding)          observe(1);
                if (bind_valid && !prev_bv)  observe(2);
                if (bind_valid && acc_ready) observe(3);
                if (enc_done)                observe(4);
                prev_bv = bind_valid;
            end
        end

        // driver and reference schedule
        initial begin
            int a, x, d, mode, st, t;
            int fch[NC];
            int acs[NC];
            int hsc[NC];
            rst          = 1'b1;
            sample_valid = 1'b0;
            abort        = 1'b0;
            acc_ready    = 1'b1;
            repeat (2) @(negedge clk);
            #3 chk_reset_outs("por");
            @(negedge clk);
            rst = 1'b0;
            @(negedge clk);
            for (int s = 0; s < 25; s++) begin
                mode = $urandom_range(0, 9);   // 0-5 plain, 6-7 abort, 8 reset, 9 abort on accept attempt
                if (g == 0 && s < 3) mode = (s == 1) ? 6 : 0;
                if (g == 1 && s == 0) mode = 8;
                sample_valid = 1'b0;
                abort        = 1'b0;
                if (!(g == 0 && s == 0)) begin
                    repeat ($urandom_range(0, 2)) begin
                        acc_ready = 1'($urandom);
                        @(negedge clk);
                    end
                end
                if (mode == 9) begin
                    sample_valid = 1'b1;
                    abort        = 1'b1;
                    @(negedge clk);
                    abort = 1'b0;
                end
                a = cyc;
                t = a + 1;
                for (int c = 0; c < NC; c++) begin
                    fch[c] = t;
                    acs[c] = t + 2 + LAT;
                    st = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : 0;
                    if (g == 0 && s == 0) st = 0;
                    if (g == 0 && s == 2) st = (c == 3) ? 5 : 0;
                    hsc[c] = acs[c] + st;
                    t = hsc[c] + 1;
                end
                d = t;
                x = d;
                if (mode == 6 || mode == 7)
                    x = ($urandom_range(0, 2) == 0) ? hsc[NC-1] : $urandom_range(a + 1, hsc[NC-1]);
                if (mode == 8)
                    x = $urandom_range(a + 1, hsc[NC-1]);
                if (g == 0 && s == 1) x = hsc[NC-1];
                if (g == 1 && s == 0) x = fch[2] + 2;
                for (int c = 0; c < NC; c++) begin
                    if (fch[c] <= x)     push(0, fch[c], c);
                    if (fch[c] + 1 <= x) push(1, fch[c] + 1, c);
                    if (acs[c] <= x)     push(2, acs[c], c);
                    if (hsc[c] <= x)     push(3, hsc[c], c);
                end
                if (x == d) push(4, d, NC - 1);
                for (int n = a; n <= x; n++) begin
                    acc_ready = 1'($urandom);
                    for (int c = 0; c < NC; c++) begin
                        if (n >= acs[c] && n < hsc[c]) acc_ready = 1'b0;
                        else if (n == hsc[c])          acc_ready = 1'b1;
                    end
                    if (g == 0 && s == 0) acc_ready = 1'b1;
                    if (n == a)
                        sample_valid = 1'b1;
                    else
                        sample_valid = (g == 0 && s == 0) ? 1'b0 : ($urandom_range(0, 3) == 0);
                    abort = (mode == 6 || mode == 7) && (n == x);
                    if (n < x) @(negedge clk);
                end
                if (mode == 8) begin
                    #2 rst = 1'b1;
                    #1 chk_reset_outs("rst_mid");
                    sample_valid = 1'b0;
                    abort        = 1'b0;
                    @(negedge clk);
                    rst = 1'b0;
                    @(negedge clk);
                    check("sample_ready_after_rst", g, sample_ready, 1);
                end else if (x != d) begin
                    @(negedge clk);
                    sample_valid = 1'b0;
                    abort        = 1'b0;
                    check("busy_after_abort",  g, busy,            0);
                    check("chunk_after_abort", g, int'(chunk_idx), 0);
                end else begin
                    @(negedge clk);
                    sample_valid = 1'b0;
`ifdef ENC_SCHED_PERF_EN
                    check("cycle_count", g, int'(cycle_count), d - a + 1);
`endif
                end
            end
            sample_valid = 1'b0;
            abort        = 1'b0;
            repeat (10) @(negedge clk);
            check("queue_drained", g, q.size(), 0);
            fin_cnt++;
        end
    end

    initial begin
        for (int i = 0; i < 40000 && fin_cnt < 2; i++) @(posedge clk);
        if (fin_cnt < 2) begin
            n_cmp++;
            n_bad++;
            $display("FAIL timeout: got %0d drivers finished, want 2", fin_cnt);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/enc_chunk_sched.md
ENC_CHUNK_SCHED -- requirements
Module: enc_chunk_sched

Interface
REQ-001 SHALL have parameter NUM_CHUNKS, default 8, the number of feature chunks (binder-pack passes) per sample.
REQ-002 SHALL have parameter BIND_LAT, default 1, the binder-pack cycles from start_encoding to valid shifted_hv; legal range 1..15.
REQ-003 SHALL have parameter CHUNK_W, default $clog2(NUM_CHUNKS), the width of chunk_idx.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 SHALL have port sample_valid, input, 1 bit: a new sample's level HVs are available.
REQ-007 SHALL have port sample_ready, output, 1 bit: the scheduler accepts a sample.
REQ-008 SHALL have port abort, input, 1 bit: cancels the sample in progress.
REQ-009 SHALL have port chunk_idx, output, CHUNK_W bits: the chunk currently selected for level-HV fetch and bind.
REQ-010 SHALL have port fetch_en, output, 1 bit: one-cycle read strobe to the level-HV memory (1-cycle read latency).
REQ-011 SHALL have port start_encoding, output, 1 bit: one-cycle strobe to the binder pack.
REQ-012 SHALL have port bind_valid, output, 1 bit: shifted_hv is valid for the accumulator.
REQ-013 SHALL have port acc_ready, input, 1 bit: the accumulator consumes shifted_hv.
REQ-014 SHALL have port enc_done, output, 1 bit: one-cycle pulse when all chunks of the sample have been accumulated.
REQ-015 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-016 SHALL implement the states IDLE, FETCH, BIND, WAIT, ACC and DONE.
REQ-017 IDLE: sample_ready=1; when sample_valid=1, SHALL clear chunk_idx to 0 and go to FETCH.
REQ-018 FETCH: fetch_en=1 for exactly one cycle, then BIND.
REQ-019 BIND: start_encoding=1 for exactly one cycle; SHALL load the latency counter with BIND_LAT-1, then go to WAIT.
REQ-020 WAIT: SHALL decrement the counter each cycle and go to ACC in the cycle after the counter reads 0.
REQ-021 ACC: bind_valid=1, held until acc_ready=1; a handshake occurs in any cycle where both are 1.
REQ-022 On an ACC handshake with chunk_idx==NUM_CHUNKS-1, SHALL go to DONE; otherwise SHALL increment chunk_idx and go to FETCH.
REQ-023 chunk_idx SHALL never wrap inside a sample and SHALL stay stable from FETCH through the ACC handshake.
REQ-024 DONE: enc_done=1 for one cycle, then IDLE.
REQ-025 sample_valid outside IDLE SHALL be ignored.
REQ-026 Per-chunk latency with acc_ready held at 1 SHALL be 3+BIND_LAT cycles; enc_done SHALL occur NUM_CHUNKS*(3+BIND_LAT)+1 cycles after the accept cycle.
REQ-027 abort=1 in any state SHALL force IDLE on the next edge, clear chunk_idx, and produce no enc_done; abort takes priority over every other transition, including an ACC handshake in the same cycle.
REQ-028 All outputs SHALL be registered or decoded from the state only (no input-to-output combinational path), except sample_ready=(state==IDLE).

Reset
REQ-029 While rst=1: state=IDLE, chunk_idx=0, counter=0, fetch_en=start_encoding=bind_valid=enc_done=busy=0, sample_ready=1.
REQ-030 rst asserted mid-sample SHALL take effect immediately; the first cycle after deassertion SHALL behave as IDLE.

Configuration
REQ-031 With ENC_SCHED_PERF_EN defined, SHALL add output cycle_count[31:0], which counts busy cycles, saturates at all-ones, clears on accept of a new sample, and resets to 0.
REQ-032 Without ENC_SCHED_PERF_EN, the cycle_count port and its logic SHALL be absent; all other behaviour is identical.

Structure
REQ-033 The state enum type and the default NUM_CHUNKS/BIND_LAT constants SHALL live in the shared package enc_sched_pkg.
REQ-034 The latency counter SHALL be the sub-module enc_lat_counter (load, decrement, zero flag); everything else is inline.

Verification
REQ-035 Reset with NUM_CHUNKS=8, BIND_LAT=1 and acc_ready=1, then sample_valid at cycle 0 -> chunk_idx steps 0..7, fetch_en at cycles 1,5,...,29, enc_done only at cycle 33.
REQ-036 acc_ready held low 5 cycles on chunk 3 -> bind_valid stays high and chunk_idx stays 3; enc_done is delayed by exactly 5 cycles.
REQ-037 abort at the ACC handshake of chunk 7 -> IDLE next cycle, no enc_done, next sample restarts at chunk_idx=0.
REQ-038 rst pulse during WAIT of chunk 2 -> all outputs at reset values asynchronously; sample_ready=1 after release.
REQ-039 BIND_LAT=4 -> exactly 4 cycles from start_encoding to bind_valid; sample_valid pulses while busy are ignored.
REQ-040 With ENC_SCHED_PERF_EN defined, the REQ-035 run -> cycle_count=34 after enc_done.
